// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: EX-stage <-> multiply/divide sequencer bundle.
//   master (EX side / HI-LO regs): start, op, rs_val, rt_val, mthi, mtlo, wdata,
//                                  mf_req, flush, hi_q, lo_q
//   slave  (muldiv_ctrl):          hi_d, lo_d, busy, done, stall
interface muldiv_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] rs_val;
  logic [DATA_WIDTH-1:0] rt_val;
  logic                  mthi;
  logic                  mtlo;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  mf_req;
  logic                  flush;
  logic [DATA_WIDTH-1:0] hi_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic [DATA_WIDTH-1:0] hi_d;
  logic [DATA_WIDTH-1:0] lo_d;
  logic                  busy;
  logic                  done;
  logic                  stall;

  modport master (
    output start, op, rs_val, rt_val, mthi, mtlo, wdata, mf_req, flush, hi_q, lo_q,
    input  hi_d, lo_d, busy, done, stall
  );

  modport slave (
    input  start, op, rs_val, rt_val, mthi, mtlo, wdata, mf_req, flush, hi_q, lo_q,
    output hi_d, lo_d, busy, done, stall
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO D inputs.
//   CLK  - clock, rising edge
//   RST  - asynchronous active-low reset
//   bus  - muldiv_ctrl_if.slave: issue/MTHI/MTLO/MF inputs, HI/LO current values,
//          HI/LO next values, busy, done pulse, combinational EX stall.
// Runs on operand magnitudes for W radix-2 steps, then applies the sign fix in FIN.
module muldiv_ctrl #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic          CLK,
  input  logic          RST,
  muldiv_ctrl_if.slave  bus
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    a_q, a_d;         // |rs|: multiplicand, or dividend for div-by-zero HI
  logic [W-1:0]    b_q, b_d;         // |rt|: divisor
  logic            is_div_q, is_div_d;
  logic            rs_neg_q, rs_neg_d;
  logic            rt_neg_q, rt_neg_d;

  logic            issue_signed;
  logic            rs_neg_c, rt_neg_c;
  logic [W-1:0]    rs_mag, rt_mag;
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next;
  logic [W:0]      div_trial;
  logic [2*W-1:0]  div_next;
  logic            sign_diff;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quot_fix, rem_fix, rs_orig;
  logic [W-1:0]    hi_nxt, lo_nxt;
  logic            done_nxt;
  logic            busy;

  // Issue-time operand magnitudes; unsigned ops never count as negative.
  always_comb begin
    issue_signed = ~bus.op[0];
    rs_neg_c     = issue_signed & bus.rs_val[W-1];
    rt_neg_c     = issue_signed & bus.rt_val[W-1];
    rs_mag       = rs_neg_c ? -bus.rs_val : bus.rs_val;
    rt_mag       = rt_neg_c ? -bus.rt_val : bus.rt_val;
  end

  // One radix-2 step: shift-add multiply (multiplier in acc low half) and
  // restoring divide (remainder in high half, quotient shifts into low half).
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + ({(W+1){acc_q[0]}} & {1'b0, a_q});
    mul_next  = {mul_sum, acc_q[W-1:1]};
    div_trial = acc_q[2*W-1:W-1] - {1'b0, b_q};
    div_next  = div_trial[W] ? {acc_q[2*W-2:0], 1'b0}
                             : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
  end

  // Sign correction applied to the magnitude result in FIN.
  always_comb begin
    sign_diff = rs_neg_q ^ rt_neg_q;
    prod_fix  = sign_diff ? -acc_q : acc_q;
    quot_fix  = sign_diff ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fix   = rs_neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    rs_orig   = rs_neg_q ? -a_q : a_q;
  end

  // Next-state, datapath and HI/LO drive.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    rs_neg_d = rs_neg_q;
    rt_neg_d = rt_neg_q;
    hi_nxt   = bus.hi_q;
    lo_nxt   = bus.lo_q;
    done_nxt = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.mthi) hi_nxt = bus.wdata;
        if (bus.mtlo) lo_nxt = bus.wdata;
        // A start issued alongside a flush belongs to a cancelled instruction.
        if (bus.start && !bus.flush) begin
          is_div_d = bus.op[1];
          rs_neg_d = rs_neg_c;
          rt_neg_d = rt_neg_c;
          a_d      = rs_mag;
          b_d      = rt_mag;
          acc_d    = {{W{1'b0}}, (bus.op[1] ? rs_mag : rt_mag)};
          count_d  = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        acc_d   = is_div_q ? div_next : mul_next;
        count_d = count_q + CW'(1);
        if (count_q == CW'(W-1)) state_d = S_FIN;
        if (bus.flush)           state_d = S_IDLE;
      end
      S_FIN: begin
        state_d = S_IDLE;
        if (!bus.flush) begin
          done_nxt = 1'b1;
          if (!is_div_q) begin
            hi_nxt = prod_fix[2*W-1:W];
            lo_nxt = prod_fix[W-1:0];
          end else if (b_q == '0) begin
            hi_nxt = rs_orig;
            lo_nxt = {W{1'b1}};
          end else begin
            hi_nxt = rem_fix;
            lo_nxt = quot_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      rs_neg_q <= 1'b0;
      rt_neg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      rs_neg_q <= rs_neg_d;
      rt_neg_q <= rt_neg_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign bus.busy  = busy;
  assign bus.done  = done_nxt;
  assign bus.hi_d  = hi_nxt;
  assign bus.lo_d  = lo_nxt;
  assign bus.stall = (bus.start | bus.mthi | bus.mtlo | bus.mf_req) & busy;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: scoreboard bench for muldiv_ctrl with a local HI/LO register pair.
module tb_muldiv_ctrl;
  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_ctrl_if #(.DATA_WIDTH(W)) bus ();

  logic [W-1:0] hi_r, lo_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r <= '0;
      lo_r <= '0;
    end else begin
      hi_r <= bus.hi_d;
      lo_r <= bus.lo_d;
    end
  end
  assign bus.hi_q = hi_r;
  assign bus.lo_q = lo_r;

  muldiv_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  // Reference results from native wide/signed arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
    exp_t            e;
    longint          p;
    longint unsigned pu;
    int              srs, srt;
    srs = rs;
    srt = rt;
    e   = '0;
    case (op)
      2'b00: begin p = longint'(srs) * longint'(srt); e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin pu = {32'd0, rs} * {32'd0, rt}; e.hi = pu[63:32]; e.lo = pu[31:0]; end
      2'b10: begin
        if (rt == '0) begin e.lo = '1; e.hi = rs; end
        else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin e.lo = 32'h8000_0000; e.hi = '0; end
        else begin e.lo = 32'(srs / srt); e.hi = 32'(srs % srt); end
      end
      default: begin
        if (rt == '0) begin e.lo = '1; e.hi = rs; end
        else begin e.lo = rs / rt; e.hi = rs % rt; end
      end
    endcase
    return e;
  endfunction

  // Called at a negedge: issues one op, pushes its expectation, returns at the
  // first negedge with busy low (HI/LO already loaded).
  task automatic issue_op(input logic [1:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt,
                          output int bc, output int dc, output bit to);
    sb.push_back(model(op, rs, rt));
    bus.start = 1'b1; bus.op = op; bus.rs_val = rs; bus.rt_val = rt;
    @(negedge clk);
    bus.start = 1'b0;
    bc = 0; dc = 0; to = 1'b0;
    while (bus.busy && !to) begin
      bc++;
      if (bus.done) dc++;
      if (bc > 100) to = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.start = 0; bus.op = 0; bus.rs_val = 0; bus.rt_val = 0; bus.mthi = 0; bus.mtlo = 0;
    bus.wdata = 0; bus.mf_req = 0; bus.flush = 0;
    rst_n = 1'b0;
    #23;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    n_cmp++; if (bus.hi_d !== '0 || bus.lo_d !== '0) begin n_err++; $display("FAIL reset_hilo_d: got %h/%h want 0/0", bus.hi_d, bus.lo_d); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0 || hi_r !== '0 || lo_r !== '0) begin n_err++; $display("FAIL reset_release: busy %b hi %h lo %h want 0/0/0", bus.busy, hi_r, lo_r); end
  endtask

  task automatic test_mul();
    logic [1:0] op; logic [W-1:0] a, b; int bc, dc; bit to; exp_t e;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
        1: begin op = 2'b00; a = 32'hFFFF_FFFD; b = 32'd7; end
        2: begin op = 2'b00; a = 32'h8000_0000; b = 32'h8000_0000; end
        default: begin op = 2'($urandom_range(0, 1)); a = $urandom; b = $urandom; end
      endcase
      issue_op(op, a, b, bc, dc, to);
      e = sb.pop_front();
      n_cmp++; if (to) begin n_err++; $display("FAIL mul%0d_timeout: busy stuck high, want low within 100", i); end
      n_cmp++; if (bc != 33) begin n_err++; $display("FAIL mul%0d_busy_cycles: got %0d want 33", i, bc); end
      n_cmp++; if (dc != 1) begin n_err++; $display("FAIL mul%0d_done: got %0d pulses want 1", i, dc); end
      n_cmp++; if (hi_r !== e.hi || lo_r !== e.lo) begin n_err++; $display("FAIL mul%0d_result %h*%h: got %h_%h want %h_%h", i, a, b, hi_r, lo_r, e.hi, e.lo); end
    end
  endtask

  task automatic test_div();
    logic [1:0] op; logic [W-1:0] a, b; int bc, dc; bit to; exp_t e;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin op = 2'b10; a = 32'hFFFF_FFF9; b = 32'd2; end
        1: begin op = 2'b11; a = 32'd7;         b = 32'd0; end
        2: begin op = 2'b10; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: begin op = 2'b10; a = 32'd7;         b = 32'hFFFF_FFFE; end
        4: begin op = 2'b10; a = 32'hFFFF_FFF9; b = 32'd0; end
        default: begin op = 2'($urandom_range(2, 3)); a = $urandom; b = $urandom >> $urandom_range(0, 28); end
      endcase
      issue_op(op, a, b, bc, dc, to);
      e = sb.pop_front();
      n_cmp++; if (to) begin n_err++; $display("FAIL div%0d_timeout: busy stuck high, want low within 100", i); end
      n_cmp++; if (bc != 33 || dc != 1) begin n_err++; $display("FAIL div%0d_timing: got busy %0d done %0d want 33/1", i, bc, dc); end
      n_cmp++; if (hi_r !== e.hi || lo_r !== e.lo) begin n_err++; $display("FAIL div%0d_result %h/%h: got hi %h lo %h want hi %h lo %h", i, a, b, hi_r, lo_r, e.hi, e.lo); end
    end
  endtask

  task automatic test_back_to_back();
    int bc, dc; bit to; exp_t e; logic [1:0] op; logic [W-1:0] a, b;
    for (int i = 0; i < 4; i++) begin
      op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
      issue_op(op, a, b, bc, dc, to);
      e = sb.pop_front();
      n_cmp++; if (to || hi_r !== e.hi || lo_r !== e.lo) begin n_err++; $display("FAIL b2b%0d op%0d: got %h_%h want %h_%h", i, op, hi_r, lo_r, e.hi, e.lo); end
    end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL b2b_queue: got %0d left want 0", sb.size()); end
  endtask

  task automatic test_stall();
    int k; exp_t e;
    sb.push_back(model(2'b11, 32'd1000, 32'd7));
    bus.start = 1'b1; bus.op = 2'b11; bus.rs_val = 32'd1000; bus.rt_val = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (bus.busy && k < 100) begin
      if (k == 4) bus.mf_req = 1'b1;
      #1;
      n_cmp++; if (bus.stall !== bus.mf_req) begin n_err++; $display("FAIL stall_busy k=%0d: got %b want %b", k, bus.stall, bus.mf_req); end
      k++;
      @(negedge clk);
    end
    #1;
    e = sb.pop_front();
    n_cmp++; if (k != 33) begin n_err++; $display("FAIL stall_len: got busy %0d want 33", k); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL stall_release: got %b want 0", bus.stall); end
    n_cmp++; if (hi_r !== e.hi || lo_r !== e.lo) begin n_err++; $display("FAIL stall_read: got %h_%h want %h_%h", hi_r, lo_r, e.hi, e.lo); end
    @(negedge clk);
    bus.mf_req = 1'b0;
  endtask

  task automatic test_mt();
    logic [W-1:0] lo_before; int k; exp_t e;
    lo_before = lo_r;
    bus.mthi = 1'b1; bus.wdata = 32'h1234;
    #1;
    n_cmp++; if (bus.hi_d !== 32'h1234) begin n_err++; $display("FAIL mthi_d: got %h want 00001234", bus.hi_d); end
    @(negedge clk);
    bus.mthi = 1'b0;
    n_cmp++; if (hi_r !== 32'h1234 || lo_r !== lo_before) begin n_err++; $display("FAIL mthi_reg: got %h/%h want 00001234/%h", hi_r, lo_r, lo_before); end
    sb.push_back(model(2'b01, 32'd3, 32'd5));
    bus.start = 1'b1; bus.op = 2'b01; bus.rs_val = 32'd3; bus.rt_val = 32'd5;
    @(negedge clk);
    bus.start = 1'b0; bus.mtlo = 1'b1; bus.wdata = 32'hCAFE;
    k = 0;
    while (bus.busy && k < 100) begin
      #1;
      n_cmp++; if (bus.stall !== 1'b1 || lo_r !== lo_before) begin n_err++; $display("FAIL mtlo_busy k=%0d: stall %b lo %h want 1/%h", k, bus.stall, lo_r, lo_before); end
      k++;
      @(negedge clk);
    end
    e = sb.pop_front();
    n_cmp++; if (k != 33 || hi_r !== e.hi || lo_r !== e.lo) begin n_err++; $display("FAIL mtlo_result: busy %0d got %h_%h want 33 %h_%h", k, hi_r, lo_r, e.hi, e.lo); end
    @(negedge clk);
    bus.mtlo = 1'b0;
    n_cmp++; if (lo_r !== 32'hCAFE || hi_r !== e.hi) begin n_err++; $display("FAIL mtlo_accept: got %h/%h want %h/0000cafe", hi_r, lo_r, e.hi); end
  endtask

  task automatic test_flush();
    logic [W-1:0] hb, lb;
    hb = hi_r; lb = lo_r;
    bus.start = 1'b1; bus.op = 2'b01; bus.rs_val = '1; bus.rt_val = '1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 10; k++) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL flush_calc_busy: got %b want 0", bus.busy); end
    n_cmp++; if (hi_r !== hb || lo_r !== lb) begin n_err++; $display("FAIL flush_calc_hilo: got %h/%h want %h/%h", hi_r, lo_r, hb, lb); end
    for (int k = 0; k < 4; k++) @(negedge clk);
    n_cmp++; if (hi_r !== hb || lo_r !== lb) begin n_err++; $display("FAIL flush_calc_late: got %h/%h want %h/%h", hi_r, lo_r, hb, lb); end
    bus.start = 1'b1; bus.op = 2'b01; bus.rs_val = '1; bus.rt_val = '1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 32; k++) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1 || bus.done !== 1'b1) begin n_err++; $display("FAIL flush_fin_reach: busy %b done %b want 1/1", bus.busy, bus.done); end
    bus.flush = 1'b1;
    #1;
    n_cmp++; if (bus.done !== 1'b0 || bus.hi_d !== hb) begin n_err++; $display("FAIL flush_fin_suppress: done %b hi_d %h want 0/%h", bus.done, bus.hi_d, hb); end
    @(negedge clk);
    bus.flush = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0 || hi_r !== hb || lo_r !== lb) begin n_err++; $display("FAIL flush_fin_hilo: busy %b got %h/%h want 0 %h/%h", bus.busy, hi_r, lo_r, hb, lb); end
  endtask

  task automatic test_rst_mid();
    bus.start = 1'b1; bus.op = 2'b11; bus.rs_val = 32'd99; bus.rt_val = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 20; k++) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1 || lo_r === '0) begin n_err++; $display("FAIL rst_pre: busy %b lo %h want 1/nonzero", bus.busy, lo_r); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL rst_mid_ctrl: busy %b done %b want 0/0", bus.busy, bus.done); end
    n_cmp++; if (hi_r !== '0 || lo_r !== '0 || bus.hi_d !== '0) begin n_err++; $display("FAIL rst_mid_hilo: got %h/%h d %h want 0", hi_r, lo_r, bus.hi_d); end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0 || hi_r !== '0 || lo_r !== '0) begin n_err++; $display("FAIL rst_after: busy %b hi %h lo %h want 0", bus.busy, hi_r, lo_r); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_stall();
    test_mt();
    test_flush();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
